mc_ctrl: RTL and testbench

Multi-cycle control unit for the RISC-V core. It sequences a shared-memory datapath (single memory for instructions and data, one ALU reused for PC increment, branch target and execute) through fetch, decode, execute, memory and writeback states. It decodes `op`/`funct3`/`funct7` into per-state mux selects, write enables and ALU operation, and handshakes with memory. It replaces the single-cycle `ctrl` when the core is built as a multi-cycle machine.

---
 rtl/core_pkg.sv | 60 ++++++
 rtl/alu_dec.sv | 22 ++
 rtl/mc_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared opcodes, FSM states and datapath select encodings for the RISC-V control units
package core_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_FUNCT
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format depends only on the opcode, so both control units share this.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    return op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// alu_dec: maps ALUOp and instruction funct fields to the ALU operation code
module alu_dec
  import core_pkg::*;
(
  input  aluop_t      alu_op,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7,
  output logic [2:0]  alu_control
);

  // Only register-register ops use funct7 to select subtract; immediates always add.
  always_comb begin
    alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                  alu_op == ALUOP_SUB ? ALU_SUB :
                  funct3 == 3'b000    ? ((op5 & funct7) ? ALU_SUB : ALU_ADD) :
                  funct3 == 3'b010    ? ALU_SLT :
                  funct3 == 3'b110    ? ALU_OR :
                  funct3 == 3'b111    ? ALU_AND : ALU_ADD;
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle RISC-V control FSM; define MC_CTRL_MEM_WAIT_EN to stall memory states on MemReady
module mc_ctrl
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       Retire,
  output logic       Illegal
);

  state_t state_q, state_d, st;
  logic   illegal_q, illegal_d;
  logic   ready;
  aluop_t alu_op;
  logic   pc_update, branch;
  logic   memreq_m, memwrite_m, irwrite_m, regwrite_m, retire_m;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign ready = MemReady;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = MemReady;
  assign ready = 1'b1;
`endif

  // Next state; memory states hold until the access completes, TRAP holds until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                            op == OP_R   ? S_EXECUTER :
                            op == OP_I   ? S_EXECUTEI :
                            op == OP_BEQ ? S_BEQ :
                            op == OP_JAL ? S_JAL : S_TRAP;
      S_MEMADR:   state_d = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER, S_EXECUTEI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ:       state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // State and sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore decode; reset presents FETCH selects so the datapath muxes are defined.
  always_comb begin
    st         = rst ? S_FETCH : state_q;
    memreq_m   = 1'b0;
    memwrite_m = 1'b0;
    irwrite_m  = 1'b0;
    regwrite_m = 1'b0;
    retire_m   = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    case (st)
      S_FETCH: begin
        memreq_m  = 1'b1;
        irwrite_m = ready;
        pc_update = ready;
        ResultSrc = RES_ALURESULT;
        ALUSrcB   = SRCB_FOUR;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        memreq_m = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        regwrite_m = 1'b1;
        retire_m   = 1'b1;
      end
      S_MEMWRITE: begin
        memreq_m   = 1'b1;
        AdrSrc     = 1'b1;
        memwrite_m = 1'b1;
        retire_m   = ready;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite_m = 1'b1;
        retire_m   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = SRCA_RD1;
        alu_op   = ALUOP_SUB;
        branch   = 1'b1;
        retire_m = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7      (funct7),
    .alu_control (ALUControl)
  );

  assign ImmSrc   = imm_src(op);
  assign MemReq   = memreq_m & ~rst;
  assign MemWrite = memwrite_m & ~rst;
  assign IRWrite  = irwrite_m & ~rst;
  assign RegWrite = regwrite_m & ~rst;
  assign Retire   = retire_m & ~rst;
  assign PCWrite  = (pc_update | (branch & Zero)) & ~rst;
  assign Illegal  = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed per-cycle vector check of the multi-cycle control FSM
module tb_mc_ctrl;

  typedef struct packed {
    logic       mreq, pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    logic       ret, ill;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z, rdy;
    out_t       e;
  } vec_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

  logic clk = 0, rst = 1, funct7 = 0, Zero = 0, MemReady = 1;
  logic [6:0] op = LW;
  logic [2:0] funct3 = 0;
  logic MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  out_t got;
  int passed = 0, total = 0;
  vec_t q[$];

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .MemReady(MemReady), .MemReq(MemReq), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Retire(Retire), .Illegal(Illegal)
  );

  assign got = {MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Retire, Illegal};

  function automatic out_t mk(input int mreq, pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ret, ill);
    return {1'(mreq), 1'(pcw), 1'(adr), 1'(mw), 1'(irw), 1'(rw), 2'(rs), 2'(sa), 2'(sb),
            2'(imm), 3'(alu), 1'(ret), 1'(ill)};
  endfunction

  function automatic out_t e_rst(input int imm, ill);   return mk(0,0,0,0,0,0,2,0,2,imm,0,0,ill); endfunction
  function automatic out_t e_fetch(input int imm);      return mk(1,1,0,0,1,0,2,0,2,imm,0,0,0); endfunction
  function automatic out_t e_decode(input int imm);     return mk(0,0,0,0,0,0,0,1,1,imm,0,0,0); endfunction
  function automatic out_t e_memadr(input int imm);     return mk(0,0,0,0,0,0,0,2,1,imm,0,0,0); endfunction
  function automatic out_t e_memrd();                   return mk(1,0,1,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic out_t e_memwb();                   return mk(0,0,0,0,0,1,1,0,0,0,0,1,0); endfunction
  function automatic out_t e_memwr(input int ret);      return mk(1,0,1,1,0,0,0,0,0,1,0,ret,0); endfunction
  function automatic out_t e_exr(input int alu);        return mk(0,0,0,0,0,0,0,2,0,0,alu,0,0); endfunction
  function automatic out_t e_exi(input int alu);        return mk(0,0,0,0,0,0,0,2,1,0,alu,0,0); endfunction
  function automatic out_t e_aluwb(input int imm);      return mk(0,0,0,0,0,1,0,0,0,imm,0,1,0); endfunction
  function automatic out_t e_beq(input int z);          return mk(0,z,0,0,0,0,0,2,0,2,1,1,0); endfunction
  function automatic out_t e_jal();                     return mk(0,1,0,0,0,0,0,1,2,3,0,0,0); endfunction
  function automatic out_t e_trap();                    return mk(0,0,0,0,0,0,0,0,0,0,0,0,1); endfunction

  task automatic add(input string n, input logic r, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy, input out_t e);
    q.push_back('{n, r, o, f3, f7, z, rdy, e});
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst; op = v.op; funct3 = v.f3; funct7 = v.f7; Zero = v.z; MemReady = v.rdy;
    #1;
    total++;
    if (got !== v.e)
      $display("FAIL %s: got %b expected %b (mreq pcw adr mw irw rw rs sa sb imm alu ret ill)",
               v.name, got, v.e);
    else
      passed++;
  endtask

  task automatic r_instr(input string n, input logic [2:0] f3, input logic f7, input int alu);
    add({n,"_f"}, 0, RT, f3, f7, 0, 1, e_fetch(0));
    add({n,"_d"}, 0, RT, f3, f7, 0, 1, e_decode(0));
    add({n,"_x"}, 0, RT, f3, f7, 0, 1, e_exr(alu));
    add({n,"_w"}, 0, RT, f3, f7, 0, 1, e_aluwb(0));
  endtask

  task automatic i_instr(input string n, input logic [2:0] f3, input logic f7, input int alu);
    add({n,"_f"}, 0, IT, f3, f7, 0, 1, e_fetch(0));
    add({n,"_d"}, 0, IT, f3, f7, 0, 1, e_decode(0));
    add({n,"_x"}, 0, IT, f3, f7, 0, 1, e_exi(alu));
    add({n,"_w"}, 0, IT, f3, f7, 0, 1, e_aluwb(0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    add("reset", 1, LW, 3'b010, 0, 0, 1, e_rst(0, 0));
    add("lw_f",  0, LW, 3'b010, 0, 0, 1, e_fetch(0));
    add("lw_d",  0, LW, 3'b010, 0, 0, 1, e_decode(0));
    add("lw_a",  0, LW, 3'b010, 0, 0, 1, e_memadr(0));
    add("lw_r",  0, LW, 3'b010, 0, 0, 1, e_memrd());
    add("lw_wb", 0, LW, 3'b010, 0, 0, 1, e_memwb());
    add("sw_f",  0, SW, 3'b010, 0, 0, 1, e_fetch(1));
    add("sw_d",  0, SW, 3'b010, 0, 0, 1, e_decode(1));
    add("sw_a",  0, SW, 3'b010, 0, 0, 1, e_memadr(1));
    add("sw_w",  0, SW, 3'b010, 0, 0, 1, e_memwr(1));
    r_instr("rsub", 3'b000, 1, 1);
    r_instr("radd", 3'b000, 0, 0);
    r_instr("rslt", 3'b010, 0, 5);
    r_instr("ror",  3'b110, 0, 3);
    i_instr("iadd7", 3'b000, 1, 0);
    i_instr("iand",  3'b111, 0, 2);
    add("beq1_f", 0, BQ, 3'b000, 0, 1, 1, e_fetch(2));
    add("beq1_d", 0, BQ, 3'b000, 0, 1, 1, e_decode(2));
    add("beq1_b", 0, BQ, 3'b000, 0, 1, 1, e_beq(1));
    add("beq0_f", 0, BQ, 3'b000, 0, 0, 1, e_fetch(2));
    add("beq0_d", 0, BQ, 3'b000, 0, 0, 1, e_decode(2));
    add("beq0_b", 0, BQ, 3'b000, 0, 0, 1, e_beq(0));
    add("jal_f",  0, JL, 3'b000, 0, 0, 1, e_fetch(3));
    add("jal_d",  0, JL, 3'b000, 0, 0, 1, e_decode(3));
    add("jal_j",  0, JL, 3'b000, 0, 0, 1, e_jal());
    add("jal_w",  0, JL, 3'b000, 0, 0, 1, e_aluwb(3));
    add("swr_f",  0, SW, 3'b010, 0, 0, 1, e_fetch(1));
    add("swr_d",  0, SW, 3'b010, 0, 0, 1, e_decode(1));
    add("swr_a",  0, SW, 3'b010, 0, 0, 1, e_memadr(1));
    add("swr_rst", 1, SW, 3'b010, 0, 0, 1, e_rst(1, 0));
    add("swr_f2", 0, LW, 3'b010, 0, 0, 1, e_fetch(0));
    add("swr_d2", 0, LW, 3'b010, 0, 0, 1, e_decode(0));
    add("swr_rst2", 1, BAD, 3'b000, 0, 0, 1, e_rst(0, 0));
    add("bad_f",  0, BAD, 3'b000, 0, 0, 1, e_fetch(0));
    add("bad_d",  0, BAD, 3'b000, 0, 0, 1, e_decode(0));
    for (int i = 0; i < 10; i++) add($sformatf("trap%0d", i), 0, BAD, 3'b000, 1, 1, 1, e_trap());
    add("trap_rst", 1, BAD, 3'b000, 0, 0, 1, e_rst(0, 1));
    add("trap_f",   0, LW, 3'b000, 0, 0, 1, e_fetch(0));
    add("end_rst",  1, LW, 3'b000, 0, 0, 1, e_rst(0, 0));
    foreach (q[i]) step(q[i]);
    q.delete();
`ifdef MC_CTRL_MEM_WAIT_EN
    add("wf_wait", 0, SW, 3'b010, 0, 0, 0, mk(1,0,0,0,0,0,2,0,2,1,0,0,0));
    add("wf_go",   0, SW, 3'b010, 0, 0, 1, e_fetch(1));
    add("w_d",     0, SW, 3'b010, 0, 0, 0, e_decode(1));
    add("w_a",     0, SW, 3'b010, 0, 0, 0, e_memadr(1));
    add("ww_1",    0, SW, 3'b010, 0, 0, 0, e_memwr(0));
    add("ww_2",    0, SW, 3'b010, 0, 0, 0, e_memwr(0));
    add("ww_3",    0, SW, 3'b010, 0, 0, 1, e_memwr(1));
    add("w_next",  0, SW, 3'b010, 0, 0, 1, e_fetch(1));
`else
    add("nf_rdy0", 0, SW, 3'b010, 0, 0, 0, e_fetch(1));
    add("n_d",     0, SW, 3'b010, 0, 0, 0, e_decode(1));
    add("n_a",     0, SW, 3'b010, 0, 0, 0, e_memadr(1));
    add("nw_rdy0", 0, SW, 3'b010, 0, 0, 0, e_memwr(1));
    add("n_next",  0, SW, 3'b010, 0, 0, 0, e_fetch(1));
`endif
    foreach (q[i]) step(q[i]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
